// File: rtl/wb_seg_reg_gen.sv
// ============================================================================
// wb_seg_reg_gen : write-back segment register with embedded dual-port data RAM
// Revision 1.0 : parametrised width, depth, read latency, store lanes
// ============================================================================
`default_nettype none

module wb_seg_reg_gen #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 12,
  parameter int RAM_LAT = 1,
  parameter int REG_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clear,
  input  logic [XLEN-1:0]            mem_a,
  input  logic [XLEN-1:0]            mem_wd,
  input  logic [1:0]                 mem_size,
  input  logic                       mem_wr,
  input  logic                       mem_rd,
  input  logic [XLEN-1:0]            result_m,
  input  logic [REG_W-1:0]           rd_m,
  input  logic [2:0]                 reg_write_m,
  input  logic                       mem_to_reg_m,
  output logic [XLEN-1:0]            result_w,
  output logic [REG_W-1:0]           rd_w,
  output logic [2:0]                 reg_write_w,
  output logic                       mem_to_reg_w,
  output logic [XLEN-1:0]            rd_data,
  output logic [$clog2(XLEN/8)-1:0]  lbs,
  output logic                       misaligned_w,
  output logic                       busy,
  input  logic [XLEN-1:0]            a2,
  input  logic [XLEN-1:0]            wd2,
  input  logic [XLEN/8-1:0]          we2,
  output logic [XLEN-1:0]            rd2
);

  localparam int NB    = XLEN / 8;
  localparam int OFF   = $clog2(NB);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  logic [OFF-1:0]    w_off;
  logic [2:0]        w_off3;
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_b;
  logic [2:0]        w_align_mask;
  logic [7:0]        w_lane8;
  logic [15:0]       w_wea_wide;
  logic              w_misaligned;
  logic              w_commit;
  logic [NB-1:0]     w_wea;
  logic [XLEN-1:0]   w_din;
  logic [XLEN-1:0]   w_ram_out;
  logic              w_unused;

  logic [XLEN-1:0]   ram_q [DEPTH];
  logic [XLEN-1:0]   ra1_q;
  logic              stall_q;
  logic              clear_q;
  logic [XLEN-1:0]   rd_old_q;

  assign w_off    = mem_a[OFF-1:0];
  assign w_off3   = 3'(w_off);
  assign w_addr_a = mem_a[OFF+ADDR_W-1:OFF];
  assign w_addr_b = a2[OFF+ADDR_W-1:OFF];
  assign w_unused = &{1'b0, mem_a[XLEN-1:OFF+ADDR_W], a2[XLEN-1:OFF+ADDR_W], a2[OFF-1:0]};

  always_comb begin
    w_align_mask = 3'b111;
    w_lane8      = 8'hFF;
    case (mem_size)
      2'd0: begin w_align_mask = 3'b000; w_lane8 = 8'h01; end
      2'd1: begin w_align_mask = 3'b001; w_lane8 = 8'h03; end
      2'd2: begin w_align_mask = 3'b011; w_lane8 = 8'h0F; end
      default: begin w_align_mask = 3'b111; w_lane8 = 8'hFF; end
    endcase
    // A double access on the 32-bit datapath can never be aligned.
    w_misaligned = (mem_rd | mem_wr) &
                   (((mem_size == 2'd3) && (XLEN == 32)) || ((w_off3 & w_align_mask) != 3'b000));
  end

  assign w_wea_wide = 16'(w_lane8) << w_off;
  assign w_commit   = mem_wr & en & ~clear & ~w_misaligned & ~rst & ~busy;
  assign w_wea      = w_commit ? w_wea_wide[NB-1:0] : '0;
  assign w_din      = mem_wd << {w_off, 3'b000};

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (w_wea[i]) ram_q[w_addr_a][8*i +: 8] <= w_din[8*i +: 8];
      if (we2[i])   ram_q[w_addr_b][8*i +: 8] <= wd2[8*i +: 8];
    end
    rd2 <= ram_q[w_addr_b];
  end

  always_ff @(posedge clk) begin
    if (rst) ra1_q <= '0;
    else     ra1_q <= ram_q[w_addr_a];
  end

  generate
    if (RAM_LAT == 2) begin : g_lat2
      logic [XLEN-1:0] ra2_q;
      state_t          state_q;
      state_t          state_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          ra2_q   <= '0;
          state_q <= S_IDLE;
        end else begin
          ra2_q   <= ra1_q;
          state_q <= state_d;
        end
      end

      // One bubble per load while the output register fills.
      always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
          S_IDLE: begin
            if (mem_rd & en & ~clear) begin
              busy    = 1'b1;
              state_d = S_WAIT;
            end
          end
          S_WAIT: begin
            if (en) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end

      assign w_ram_out = ra2_q;
    end else begin : g_lat1
      assign busy      = 1'b0;
      assign w_ram_out = ra1_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      result_w     <= '0;
      rd_w         <= '0;
      reg_write_w  <= '0;
      mem_to_reg_w <= 1'b0;
      lbs          <= '0;
      misaligned_w <= 1'b0;
      stall_q      <= 1'b0;
      clear_q      <= 1'b0;
      rd_old_q     <= '0;
    end else begin
      if (en & ~busy) begin
        if (clear) begin
          result_w     <= '0;
          rd_w         <= '0;
          reg_write_w  <= '0;
          mem_to_reg_w <= 1'b0;
          lbs          <= '0;
          misaligned_w <= 1'b0;
        end else begin
          result_w     <= result_m;
          rd_w         <= rd_m;
          reg_write_w  <= reg_write_m;
          mem_to_reg_w <= mem_to_reg_m;
          lbs          <= w_off;
          misaligned_w <= w_misaligned;
        end
      end
      stall_q  <= ~(en & ~busy);
      clear_q  <= en & clear;
      rd_old_q <= rd_data;
    end
  end

  assign rd_data = stall_q ? rd_old_q : (clear_q ? '0 : w_ram_out);

endmodule

`default_nettype wire
